// File: rtl/rgmii_rx_frame_checker.sv
// Receive frame qualifier: strips preamble/SFD and FCS, checks CRC-32, length and
// PHY error, and forwards the payload with a good/bad verdict on the last byte.
module rgmii_rx_frame_checker #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk125,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_val,
  input  logic        in_err,
  input  logic        in_sof,
  input  logic        in_eof,
  output logic [7:0]  out_data,
  output logic        out_val,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_good,
  output logic        out_bad,
  output logic [15:0] cnt_good,
  output logic [15:0] cnt_bad,
  output logic [15:0] cnt_drop
);

  typedef enum logic [1:0] {IDLE, PRE, PAY, DROP} state_t;

  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [10:0] MIN_L       = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L       = 11'(MAX_LEN);

  function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [15:0] satAdd(input logic [15:0] c, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, c} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  state_t            stateReg, stateNext;
  logic [2:0]        preCntReg, preCntNext;
  logic [31:0]       crcReg, crcNext;
  logic [10:0]       lenReg, lenNext;
  logic              errReg, errNext;
  logic [3:0][7:0]   dlyReg, dlyNext, dlyShift;
  logic [2:0]        heldReg, heldNext;
  logic              emittedReg, emittedNext;

  logic [7:0]        outDataReg, outDataNext;
  logic              outValReg, outValNext;
  logic              outSofReg, outSofNext;
  logic              outEofReg, outEofNext;
  logic              outGoodReg, outGoodNext;
  logic              outBadReg, outBadNext;
  logic [15:0]       cntGoodReg, cntBadReg, cntDropReg;

  logic              incGood, incBad;
  logic [1:0]        dropInc;
  logic [31:0]       crcUpd;
  logic [10:0]       lenInc;
  logic              errUpd;
  logic              frameOk;
  state_t            sofState;
  logic              sofDrop;

  // Delay line: newest byte enters slot 0, slot 3 is the next byte to emit.
  assign dlyShift[0] = in_data;
  for (genvar gi = 1; gi < 4; gi++) begin : gShift
    assign dlyShift[gi] = dlyReg[gi-1];
  end

  assign crcUpd  = crcByte(crcReg, in_data);
  assign lenInc  = (lenReg == 11'h7FF) ? lenReg : lenReg + 11'd1;
  assign errUpd  = errReg | in_err;
  assign frameOk = (crcUpd == CRC_RESIDUE) && (lenInc >= MIN_L) && (lenInc <= MAX_L) && !errUpd;

  // How a start-of-frame byte is handled, whichever state it interrupts.
  always_comb begin
    sofDrop  = 1'b0;
    sofState = DROP;
    if (in_eof) begin
      sofDrop  = 1'b1;
      sofState = IDLE;
    end else if (in_data == 8'h55) begin
      sofState = PRE;
    end
  end

  always_comb begin
    stateNext   = stateReg;
    preCntNext  = preCntReg;
    crcNext     = crcReg;
    lenNext     = lenReg;
    errNext     = errReg;
    dlyNext     = dlyReg;
    heldNext    = heldReg;
    emittedNext = emittedReg;
    outDataNext = 8'd0;
    outValNext  = 1'b0;
    outSofNext  = 1'b0;
    outEofNext  = 1'b0;
    outGoodNext = 1'b0;
    outBadNext  = 1'b0;
    incGood     = 1'b0;
    incBad      = 1'b0;
    dropInc     = 2'd0;
    if (in_val) begin
      case (stateReg)
        IDLE: begin
          if (in_sof) begin
            stateNext  = sofState;
            preCntNext = 3'd1;
            dropInc    = {1'b0, sofDrop};
          end
        end
        PRE: begin
          if (in_sof) begin
            stateNext  = sofState;
            preCntNext = 3'd1;
            dropInc    = 2'd1 + {1'b0, sofDrop};
          end else if (in_eof) begin
            stateNext = IDLE;
            dropInc   = 2'd1;
          end else if (in_err) begin
            stateNext = DROP;
          end else if (in_data == 8'h55 && preCntReg < 3'd7) begin
            preCntNext = preCntReg + 3'd1;
          end else if (in_data == 8'hD5) begin
            stateNext   = PAY;
            crcNext     = CRC_INIT;
            lenNext     = 11'd0;
            errNext     = 1'b0;
            heldNext    = 3'd0;
            emittedNext = 1'b0;
          end else begin
            stateNext = DROP;
          end
        end
        DROP: begin
          if (in_sof) begin
            stateNext  = sofState;
            preCntNext = 3'd1;
            dropInc    = 2'd1 + {1'b0, sofDrop};
          end else if (in_eof) begin
            stateNext = IDLE;
            dropInc   = 2'd1;
          end
        end
        PAY: begin
          if (in_sof) begin
            // Missing EoF: close the open frame with a data-less bad marker.
            incBad     = 1'b1;
            outEofNext = emittedReg;
            outBadNext = emittedReg;
            stateNext  = sofState;
            preCntNext = 3'd1;
            dropInc    = {1'b0, sofDrop};
          end else begin
            crcNext  = crcUpd;
            lenNext  = lenInc;
            errNext  = errUpd;
            dlyNext  = dlyShift;
            heldNext = (heldReg == 3'd4) ? heldReg : heldReg + 3'd1;
            if (heldReg == 3'd4) begin
              outValNext  = 1'b1;
              outDataNext = dlyReg[3];
              outSofNext  = !emittedReg;
              emittedNext = 1'b1;
            end
            if (in_eof) begin
              stateNext = IDLE;
              if (heldReg == 3'd4) begin
                outEofNext  = 1'b1;
                outGoodNext = frameOk;
                outBadNext  = !frameOk;
                incGood     = frameOk;
                incBad      = !frameOk;
              end else begin
                incBad = 1'b1;
              end
            end
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk125 or posedge rst) begin
    if (rst) begin
      stateReg   <= IDLE;
      preCntReg  <= 3'd0;
      crcReg     <= CRC_INIT;
      lenReg     <= 11'd0;
      errReg     <= 1'b0;
      dlyReg     <= '0;
      heldReg    <= 3'd0;
      emittedReg <= 1'b0;
      outDataReg <= 8'd0;
      outValReg  <= 1'b0;
      outSofReg  <= 1'b0;
      outEofReg  <= 1'b0;
      outGoodReg <= 1'b0;
      outBadReg  <= 1'b0;
      cntGoodReg <= 16'd0;
      cntBadReg  <= 16'd0;
      cntDropReg <= 16'd0;
    end else begin
      stateReg   <= stateNext;
      preCntReg  <= preCntNext;
      crcReg     <= crcNext;
      lenReg     <= lenNext;
      errReg     <= errNext;
      dlyReg     <= dlyNext;
      heldReg    <= heldNext;
      emittedReg <= emittedNext;
      outDataReg <= outDataNext;
      outValReg  <= outValNext;
      outSofReg  <= outSofNext;
      outEofReg  <= outEofNext;
      outGoodReg <= outGoodNext;
      outBadReg  <= outBadNext;
      cntGoodReg <= satAdd(cntGoodReg, {1'b0, incGood});
      cntBadReg  <= satAdd(cntBadReg, {1'b0, incBad});
      cntDropReg <= satAdd(cntDropReg, dropInc);
    end
  end

  assign out_data = outDataReg;
  assign out_val  = outValReg;
  assign out_sof  = outSofReg;
  assign out_eof  = outEofReg;
  assign out_good = outGoodReg;
  assign out_bad  = outBadReg;
  assign cnt_good = cntGoodReg;
  assign cnt_bad  = cntBadReg;
  assign cnt_drop = cntDropReg;

endmodule

// File: tb/tb_rgmii_rx_frame_checker.sv
// Scoreboard bench for rgmii_rx_frame_checker: frames are built with their FCS here,
// expected output events are queued per driven byte tagged with the cycle they are due.
module tb_rgmii_rx_frame_checker;

  logic        clk125, rst;
  logic [7:0]  in_data;
  logic        in_val, in_err, in_sof, in_eof;
  logic [7:0]  out_data;
  logic        out_val, out_sof, out_eof, out_good, out_bad;
  logic [15:0] cnt_good, cnt_bad, cnt_drop;

  rgmii_rx_frame_checker #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
    .clk125(clk125), .rst(rst),
    .in_data(in_data), .in_val(in_val), .in_err(in_err), .in_sof(in_sof), .in_eof(in_eof),
    .out_data(out_data), .out_val(out_val), .out_sof(out_sof), .out_eof(out_eof),
    .out_good(out_good), .out_bad(out_bad),
    .cnt_good(cnt_good), .cnt_bad(cnt_bad), .cnt_drop(cnt_drop)
  );

  typedef struct {
    int         cyc;
    bit         val;
    logic [7:0] data;
    bit         sof, eof, good, bad;
  } exp_t;

  exp_t       expQ[$];
  logic [7:0] fbuf[$];
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  bit         abortPending;
  int         eGood, eBad, eDrop;

  initial begin
    clk125 = 1'b0;
    forever #4 clk125 = ~clk125;
  end

  always @(posedge clk125) cyc <= cyc + 1;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, got, exp);
    end
  endtask

  always @(negedge clk125) begin
    exp_t e;
    if (expQ.size() > 0 && expQ[0].cyc < cyc) begin
      checkEq("late", cyc, expQ[0].cyc);
      void'(expQ.pop_front());
    end
    if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
      e = expQ.pop_front();
      checkEq("ctl", {out_val, out_sof, out_eof, out_good, out_bad},
              {e.val, e.sof, e.eof, e.good, e.bad});
      if (e.val) checkEq("data", out_data, e.data);
    end else begin
      checkEq("idle", {out_val, out_sof, out_eof, out_good, out_bad}, 5'b0);
    end
  end

  function automatic logic [31:0] refCrc(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic        fbk;
    r = c;
    for (int b = 0; b < 8; b++) begin
      fbk = r[0] ^ d[b];
      r   = {1'b0, r[31:1]} ^ ({32{fbk}} & 32'hEDB88320);
    end
    return r;
  endfunction

  // Preamble, SFD, payLen random bytes and a correct FCS sent LSB first.
  task automatic buildGood(input int payLen);
    logic [31:0] c;
    logic [31:0] fcs;
    logic [7:0]  b;
    fbuf.delete();
    repeat (7) fbuf.push_back(8'h55);
    fbuf.push_back(8'hD5);
    c = 32'hFFFFFFFF;
    for (int i = 0; i < payLen; i++) begin
      b = 8'($urandom_range(0, 255));
      fbuf.push_back(b);
      c = refCrc(c, b);
    end
    fcs = ~c;
    for (int k = 0; k < 4; k++) fbuf.push_back(fcs[8*k +: 8]);
  endtask

  task automatic tick();
    @(posedge clk125);
    #1;
  endtask

  task automatic idle(input int n);
    in_val = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_err = 1'b0;
    repeat (n) tick();
  endtask

  // sfdIdx < 0 marks a frame that must never reach PAY.
  task automatic sendFrame(input int sfdIdx, input int errIdx, input int gap,
                           input bit expGood, input bit withEof);
    int   last;
    int   j;
    exp_t e;
    last = fbuf.size() - 1;
    for (int i = 0; i <= last; i++) begin
      idle(gap);
      in_data = fbuf[i];
      in_val  = 1'b1;
      in_sof  = (i == 0);
      in_eof  = withEof && (i == last);
      in_err  = (i == errIdx);
      if (i == 0 && abortPending) begin
        e = '{cyc: cyc + 1, val: 1'b0, data: 8'd0, sof: 1'b0, eof: 1'b1, good: 1'b0, bad: 1'b1};
        expQ.push_back(e);
        abortPending = 1'b0;
      end
      j = i - sfdIdx - 1;
      if (sfdIdx >= 0 && j >= 4) begin
        e.cyc  = cyc + 1;
        e.val  = 1'b1;
        e.data = fbuf[i - 4];
        e.sof  = (j == 4);
        e.eof  = withEof && (i == last);
        e.good = e.eof && expGood;
        e.bad  = e.eof && !expGood;
        expQ.push_back(e);
      end
      tick();
    end
    in_val = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_err = 1'b0;
    if (!withEof) abortPending = (sfdIdx >= 0) && (last - sfdIdx - 1 >= 4);
  endtask

  task automatic checkCounters(input string tag);
    idle(2);
    checkEq({tag, ".cnt_good"}, {16'd0, cnt_good}, eGood);
    checkEq({tag, ".cnt_bad"},  {16'd0, cnt_bad},  eBad);
    checkEq({tag, ".cnt_drop"}, {16'd0, cnt_drop}, eDrop);
  endtask

  initial begin
    rst = 1'b1;
    in_data = 8'd0; in_val = 1'b0; in_err = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
    abortPending = 1'b0;
    eGood = 0; eBad = 0; eDrop = 0;
    repeat (3) @(posedge clk125);
    #1 rst = 1'b0;
    checkCounters("reset");

    buildGood(60);
    sendFrame(7, -1, 0, 1'b1, 1'b1); eGood++;
    checkCounters("good60");

    sendFrame(7, -1, 9, 1'b1, 1'b1); eGood++;
    checkCounters("sparse60");

    buildGood(60);
    fbuf[7 + 10] = fbuf[7 + 10] ^ 8'h01;
    sendFrame(7, -1, 0, 1'b0, 1'b1); eBad++;
    checkCounters("crcbad");

    buildGood(60);
    sendFrame(7, 7 + 20, 0, 1'b0, 1'b1); eBad++;
    checkCounters("phyerr");

    buildGood(1515);
    sendFrame(7, -1, 0, 1'b0, 1'b1); eBad++;
    checkCounters("len1519");

    buildGood(1514);
    sendFrame(7, -1, 0, 1'b1, 1'b1); eGood++;
    checkCounters("len1518");

    buildGood(59);
    sendFrame(7, -1, 0, 1'b0, 1'b1); eBad++;
    checkCounters("len63");

    buildGood(0);
    sendFrame(7, -1, 0, 1'b0, 1'b1); eBad++;
    checkCounters("runt4");

    buildGood(1);
    sendFrame(7, -1, 0, 1'b0, 1'b1); eBad++;
    checkCounters("runt5");

    buildGood(60);
    fbuf[1] = 8'h54;
    sendFrame(-1, -1, 0, 1'b0, 1'b1); eDrop++;
    checkCounters("pre54");

    buildGood(60);
    repeat (7) void'(fbuf.pop_front());
    sendFrame(-1, -1, 0, 1'b0, 1'b1); eDrop++;
    checkCounters("sofD5");

    buildGood(60);
    fbuf.push_front(8'h55);
    sendFrame(-1, -1, 0, 1'b0, 1'b1); eDrop++;
    checkCounters("pre8");

    buildGood(60);
    while (fbuf.size() > 7 + 1 + 29) void'(fbuf.pop_back());
    sendFrame(7, -1, 0, 1'b0, 1'b0);
    buildGood(60);
    sendFrame(7, -1, 0, 1'b1, 1'b1); eBad++; eGood++;
    checkCounters("abort");

    buildGood(60);
    sendFrame(7, -1, 0, 1'b1, 1'b1);
    buildGood(64);
    sendFrame(7, -1, 0, 1'b1, 1'b1); eGood += 2;
    checkCounters("b2b");

    buildGood(60);
    while (fbuf.size() > 7 + 1 + 10) void'(fbuf.pop_back());
    sendFrame(7, -1, 0, 1'b0, 1'b0);
    abortPending = 1'b0;
    idle(1);
    rst = 1'b1;
    eGood = 0; eBad = 0; eDrop = 0;
    idle(2);
    checkEq("inrst.cnt_good", {16'd0, cnt_good}, eGood);
    checkEq("inrst.cnt_bad",  {16'd0, cnt_bad},  eBad);
    checkEq("inrst.cnt_drop", {16'd0, cnt_drop}, eDrop);
    rst = 1'b0;
    checkCounters("postrst");
    buildGood(60);
    sendFrame(7, -1, 0, 1'b1, 1'b1); eGood++;
    checkCounters("afterrst");

    idle(4);
    checkEq("drain", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rgmii_rx_frame_checker.md
# rgmii_rx_frame_checker

Receive-side frame qualifier in the clk125 domain, directly downstream of the RGMII over-clock module's byte stream (Data/Val/Err/SoF/EoF). It strips preamble/SFD and the 4-byte FCS, and checks CRC-32, length and PHY error per frame. It forwards the payload (destination MAC through last data byte) with a per-frame good/bad verdict on the last byte, and keeps saturating frame statistics.

## Interface
- MIN_LEN, 64, minimum legal length in bytes (SFD excluded, FCS included)
- MAX_LEN, 1518, maximum legal length, same counting; must be ≤ 2046
- clk125  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_data  in  8  received byte
- in_val  in  1  byte strobe; may be sparse (10/100 Mb/s gaps)
- in_err  in  1  PHY error on this byte, qualified by in_val
- in_sof  in  1  first byte of frame, qualified by in_val
- in_eof  in  1  last byte of frame, qualified by in_val
- out_data  out  8  payload byte
- out_val  out  1  out_data valid
- out_sof  out  1  first payload byte
- out_eof  out  1  last payload byte, or abort marker
- out_good  out  1  frame passed all checks, only with out_eof
- out_bad  out  1  frame failed, only with out_eof
- cnt_good  out  16  good frames, saturating at 0xFFFF
- cnt_bad  out  16  bad frames (SFD seen), saturating
- cnt_drop  out  16  frames discarded before SFD, saturating

## Operation
- States: IDLE, PRE, PAY, DROP. All input flags are ignored when in_val=0; state holds across gaps.
- IDLE, in_sof & in_val:
  - byte 0x55 → PRE, preamble count=1
  - any other byte → DROP
  - in_eof on the same byte → cnt_drop++, stay IDLE
- PRE:
  - 0x55 with count<7 → count++
  - 0xD5 → PAY; clear CRC to 0xFFFFFFFF, length=0, err flag=0
  - any other byte, 8th 0x55, or in_err → DROP
  - in_eof → cnt_drop++, IDLE
- DROP: discard bytes until in_eof, then cnt_drop++, IDLE.
- PAY:
  - Every byte is shifted into a 4-byte delay line and updates the CRC: reflected, poly 0xEDB88320, LSB first.
  - Length is an 11-bit counter saturating at 2047.
  - in_err sets the err flag.
  - Once 4 bytes are held, each new byte pushes the oldest to the output. The first pushed byte carries out_sof.
- End of frame (in_eof in PAY): the byte pushed out carries out_eof. Checks, applied with the CRC including the final byte:
  - good if CRC register = 0xDEBB20E3, MIN_LEN ≤ length ≤ MAX_LEN, and err flag=0; else bad
  - exactly one of out_good/out_bad with out_eof
  - cnt_good or cnt_bad increments
  - return to IDLE
- Length ≤4 at in_eof: no byte has been emitted; emit nothing, cnt_bad++.
- in_sof in PAY (missing EoF): abort the current frame.
  - if any byte was already emitted, one cycle of out_eof=1, out_bad=1, out_val=0
  - cnt_bad++
  - the sof byte is then handled exactly as in IDLE, in the same cycle
- in_sof in PRE or DROP: count the old frame as drop, restart as in IDLE.

## Timing
- All outputs are registered. out_val/out_data/out_sof/out_eof/out_good/out_bad are asserted exactly one cycle after the in_val that caused them, for one cycle.
- Effective byte latency: 4 input bytes plus 1 cycle.
- Counters update in the same cycle as out_eof, or one cycle after the in_eof for drops and runts.
- Reset: state IDLE, all outputs 0, counters 0, delay line 0, CRC 0xFFFFFFFF. Assertion mid-frame discards the frame without incrementing any counter. The first frame after release is processed normally only if its in_sof arrives after release; bytes before that go to IDLE and are ignored.
- Back-to-back frames (in_eof followed by in_sof on the next cycle) are supported with no lost bytes.

## Test plan
- 7×0x55, 0xD5, 60-byte payload, correct FCS, in_val every cycle → 60 out_val bytes matching the payload; out_sof on byte 1; out_eof+out_good on byte 60; cnt_good=1.
- Same frame with in_val 1 cycle in 10 → identical output data; each out_val exactly 1 cycle after the corresponding in_val.
- Corrupted payload byte / in_err on byte 20 / 1519-byte frame / 63-byte frame → out_eof with out_bad, and cnt_bad=1 for each case.
- Preamble 0x55,0x54 / sof byte 0xD5 / 8×0x55+0xD5 → no out_val; cnt_drop increments per frame.
- in_sof during PAY at byte 30, then a good frame → abort cycle (out_eof, out_bad, out_val=0), then the good frame passes; cnt_bad=1, cnt_good=1.
- rst pulsed at payload byte 10, then a good frame → all outputs 0 during and after reset; counters 0; next frame good with cnt_good=1.
